// File: rtl/reg_hazard_ctrl.sv
// Register-file hazard/forwarding controller beside ID: tracks EX/MEM producers,
// raises the ID interlock and picks the EX-stage operand source per read port.

module reg_hazard_src #(
  parameter bit FORWARDING = 1'b1
) (
  input  logic       i_used,
  input  logic [3:0] i_id,
  input  logic       i_exVld,
  input  logic [3:0] i_exId,
  input  logic       i_exLd,
  input  logic       i_memVld,
  input  logic [3:0] i_memId,
  output logic       o_req,
  output logic [1:0] o_sel
);
  logic w_exHit, w_memHit;

  assign w_exHit  = i_used & i_exVld  & (i_exId  == i_id);
  assign w_memHit = i_used & i_memVld & (i_memId == i_id);

  // EX checked first so the newest producer wins; a load in EX is not ready yet
  assign o_req = FORWARDING ? (w_exHit & i_exLd) : (w_exHit | w_memHit);
  assign o_sel = !FORWARDING ? 2'b00 :
                 w_exHit     ? (i_exLd ? 2'b00 : 2'b01) :
                 w_memHit    ? 2'b10 : 2'b00;
endmodule

module reg_hazard_ctrl #(
  parameter bit FORWARDING = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             issueValid,
  input  logic             srcAUsed,
  input  logic [1:0]       srcASpec,
  input  logic [2:0]       srcAIdx,
  input  logic             srcBUsed,
  input  logic [2:0]       srcBIdx,
  input  logic             dstWrite,
  input  logic [1:0]       dstSpec,
  input  logic [2:0]       dstIdx,
  input  logic             dstIsLoad,
  input  logic             flush,
  input  logic             hold,
  output logic             stall,
  output logic [1:0]       fwdSelA,
  output logic [1:0]       fwdSelB,
  output logic [CNT_W-1:0] stallCount
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic       vld;
    logic [3:0] id;
    logic       ld;
  } slot_t;

  function automatic logic [3:0] f_regId(input logic [1:0] spec, input logic [2:0] idx);
    case (spec)
      2'b00:   return {1'b0, idx};
      2'b01:   return 4'd8;
      2'b10:   return 4'd9;
      default: return 4'd10;
    endcase
  endfunction

  slot_t            r_ex;
  logic             r_memVld;
  logic [3:0]       r_memId;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_PORTS-1:0]      w_used;
  logic [NUM_PORTS-1:0][3:0] w_id;
  logic [NUM_PORTS-1:0]      w_req;
  logic [NUM_PORTS-1:0][1:0] w_sel;
  logic                      w_stall;

  assign w_used = {srcBUsed, srcAUsed};
  assign w_id   = {{1'b0, srcBIdx}, f_regId(srcASpec, srcAIdx)};

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      reg_hazard_src #(.FORWARDING(FORWARDING)) u_src (
        .i_used  (w_used[p]),
        .i_id    (w_id[p]),
        .i_exVld (r_ex.vld),
        .i_exId  (r_ex.id),
        .i_exLd  (r_ex.ld),
        .i_memVld(r_memVld),
        .i_memId (r_memId),
        .o_req   (w_req[p]),
        .o_sel   (w_sel[p])
      );
    end
  endgenerate

  assign w_stall    = issueValid & ~flush & (|w_req);
  assign stall      = w_stall;
  assign fwdSelA    = w_sel[0];
  assign fwdSelB    = w_sel[1];
  assign stallCount = r_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ex     <= '0;
      r_memVld <= 1'b0;
      r_memId  <= '0;
      r_cnt    <= '0;
    end else if (!hold) begin
      r_memVld <= r_ex.vld;
      r_memId  <= r_ex.id;
      // a squashed or interlocked ID slot enters EX as a bubble
      r_ex     <= '{vld: issueValid & dstWrite & ~flush & ~w_stall,
                    id:  f_regId(dstSpec, dstIdx),
                    ld:  dstIsLoad};
      if (w_stall && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// Scoreboard bench for reg_hazard_ctrl: expected ID-stage outputs are queued
// as each instruction is driven and compared on the following negedge.

module tb_reg_hazard_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1, RST2 = 1'b1;
  logic issueValid, srcAUsed, srcBUsed, dstWrite, dstIsLoad, flush, hold;
  logic [1:0] srcASpec, dstSpec;
  logic [2:0] srcAIdx, srcBIdx, dstIdx;
  logic stall, stall2;
  logic [1:0] fwdSelA, fwdSelB, fwdSelA2, fwdSelB2;
  logic [15:0] stallCount;
  logic [3:0]  stallCount2;

  always #5 CLK = ~CLK;

  reg_hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .issueValid(issueValid),
    .srcAUsed(srcAUsed), .srcASpec(srcASpec), .srcAIdx(srcAIdx),
    .srcBUsed(srcBUsed), .srcBIdx(srcBIdx),
    .dstWrite(dstWrite), .dstSpec(dstSpec), .dstIdx(dstIdx), .dstIsLoad(dstIsLoad),
    .flush(flush), .hold(hold),
    .stall(stall), .fwdSelA(fwdSelA), .fwdSelB(fwdSelB), .stallCount(stallCount)
  );

  // no-forwarding variant with a narrow counter so saturation is reachable quickly
  reg_hazard_ctrl #(.FORWARDING(1'b0), .CNT_W(4)) dut_nf (
    .CLK(CLK), .RST(RST2), .issueValid(issueValid),
    .srcAUsed(srcAUsed), .srcASpec(srcASpec), .srcAIdx(srcAIdx),
    .srcBUsed(srcBUsed), .srcBIdx(srcBIdx),
    .dstWrite(dstWrite), .dstSpec(dstSpec), .dstIdx(dstIdx), .dstIsLoad(dstIsLoad),
    .flush(flush), .hold(hold),
    .stall(stall2), .fwdSelA(fwdSelA2), .fwdSelB(fwdSelB2), .stallCount(stallCount2)
  );

  typedef struct {
    logic iv, aU;
    logic [1:0] aS;
    logic [2:0] aI;
    logic bU;
    logic [2:0] bI;
    logic wr;
    logic [1:0] dS;
    logic [2:0] dI;
    logic ld;
  } ins_t;

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  a, b;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   nchk = 0, nerr = 0;
  logic [15:0] expCnt = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic ins_t mk(logic aU, logic [1:0] aS, logic [2:0] aI, logic bU, logic [2:0] bI,
                              logic wr, logic [1:0] dS, logic [2:0] dI, logic ld);
    ins_t t;
    t.iv = 1'b1; t.aU = aU; t.aS = aS; t.aI = aI; t.bU = bU; t.bI = bI;
    t.wr = wr; t.dS = dS; t.dI = dI; t.ld = ld;
    return t;
  endfunction

  task automatic apply(input ins_t t, input logic fl, input logic hd);
    issueValid = t.iv; srcAUsed = t.aU; srcASpec = t.aS; srcAIdx = t.aI;
    srcBUsed = t.bU; srcBIdx = t.bI; dstWrite = t.wr; dstSpec = t.dS;
    dstIdx = t.dI; dstIsLoad = t.ld; flush = fl; hold = hd;
  endtask

  task automatic step(input string tag, input ins_t t, input logic fl, input logic hd,
                      input logic es, input logic [1:0] ea, input logic [1:0] eb);
    exp_t e;
    @(posedge CLK); #1;
    apply(t, fl, hd);
    e.tag = tag; e.st = es; e.a = ea; e.b = eb; e.cnt = expCnt;
    exp_q.push_back(e);
    if (es && !hd) expCnt++;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_stall"}, stall, e.st);
      chk({e.tag, "_selA"}, fwdSelA, e.a);
      chk({e.tag, "_selB"}, fwdSelB, e.b);
      chk({e.tag, "_cnt"}, stallCount, e.cnt);
    end
  end

  ins_t nop;

  initial begin
    nop = mk(0,0,0, 0,0, 0,0,0,0);
    nop.iv = 1'b0;
    apply(nop, 0, 0);
    @(negedge CLK);
    chk("init_stall", stall, 0);
    chk("init_cnt", stallCount, 0);
    RST = 1'b0;

    // load-use to get a counted stall, then reset with live slots
    step("s1", mk(0,0,0, 0,0, 1,0,1,1), 0, 0, 0, 0, 0);
    step("s2", mk(0,0,0, 1,1, 1,0,6,0), 0, 0, 1, 0, 0);
    step("s3", mk(0,0,0, 1,1, 1,0,6,0), 0, 0, 0, 0, 2);
    step("s4", mk(0,0,0, 0,0, 1,0,1,1), 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    apply(mk(1,0,1, 0,0, 0,0,0,0), 0, 0);
    #1;
    chk("prerst_stall", stall, 1);
    chk("prerst_cnt", stallCount, 1);
    RST = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_selA", fwdSelA, 0);
    chk("rst_selB", fwdSelB, 0);
    chk("rst_cnt", stallCount, 0);
    @(negedge CLK);
    RST = 1'b0;
    expCnt = '0;
    step("postrst", mk(1,0,1, 0,0, 0,0,0,0), 0, 0, 0, 0, 0);

    // ALU chain
    step("alu1", mk(1,0,2, 1,3, 1,0,1,0), 0, 0, 0, 0, 0);
    step("alu2", mk(1,0,1, 1,1, 1,0,4,0), 0, 0, 0, 1, 1);
    step("alu3", mk(1,0,1, 0,0, 1,0,5,0), 0, 0, 0, 2, 0);
    step("alu4", mk(1,0,1, 1,1, 0,0,0,0), 0, 0, 0, 0, 0);

    // load-use on port 2
    step("lu1", mk(0,0,0, 0,0, 1,0,5,1), 0, 0, 0, 0, 0);
    step("lu2", mk(1,0,0, 1,5, 1,0,7,0), 0, 0, 1, 0, 0);
    step("lu3", mk(1,0,0, 1,5, 1,0,7,0), 0, 0, 0, 0, 2);

    // special registers
    step("sp1", mk(0,0,0, 0,0, 1,1,0,0), 0, 0, 0, 0, 0);
    step("sp2", mk(1,1,0, 0,0, 0,0,0,0), 0, 0, 0, 1, 0);
    step("sp3", mk(0,0,0, 0,0, 1,1,0,0), 0, 0, 0, 0, 0);
    step("sp4", mk(1,3,0, 1,0, 0,0,0,0), 0, 0, 0, 0, 0);
    step("sp5", mk(1,0,0, 0,0, 0,0,0,0), 0, 0, 0, 0, 0);

    // newest producer wins
    step("nw1", mk(0,0,0, 0,0, 1,0,2,1), 0, 0, 0, 0, 0);
    step("nw2", mk(0,0,0, 0,0, 1,0,2,0), 0, 0, 0, 0, 0);
    step("nw3", mk(1,0,2, 0,0, 0,0,0,0), 0, 0, 0, 1, 0);

    // flush on a load-use consumer: no stall, its write becomes a bubble
    step("fl1", mk(0,0,0, 0,0, 1,0,3,1), 0, 0, 0, 0, 0);
    step("fl2", mk(1,0,3, 0,0, 1,0,6,0), 1, 0, 0, 0, 0);
    step("fl3", mk(1,0,3, 1,6, 1,0,2,0), 0, 0, 0, 2, 0);

    // hold during a stall: slots and counter frozen
    step("hd1", mk(0,0,0, 0,0, 1,0,4,1), 0, 0, 0, 0, 0);
    step("hd2", mk(1,0,2, 1,4, 1,0,7,0), 0, 1, 1, 2, 0);
    step("hd3", mk(1,0,2, 1,4, 1,0,7,0), 0, 1, 1, 2, 0);
    step("hd4", mk(1,0,2, 1,4, 1,0,7,0), 0, 1, 1, 2, 0);
    step("hd5", mk(1,0,2, 1,4, 1,0,7,0), 0, 0, 1, 2, 0);
    step("hd6", mk(1,0,2, 1,4, 1,0,7,0), 0, 0, 0, 0, 2);
    step("hd7", nop, 0, 0, 0, 0, 0);
    @(negedge CLK);

    // no-forwarding instance: R1 <- R1 every cycle gives advance, stall, stall
    RST2 = 1'b0;
    apply(mk(1,0,1, 1,1, 1,0,1,0), 0, 0);
    #1;
    chk("nf_k0_stall", stall2, 0);
    for (int k = 1; k <= 68; k++) begin
      @(negedge CLK); #1;
      if (k == 1) begin
        chk("nf_k1_stall", stall2, 1);
        chk("nf_k1_selA", fwdSelA2, 0);
        chk("nf_k1_cnt", stallCount2, 0);
      end
      if (k == 2) begin
        chk("nf_k2_stall", stall2, 1);
        chk("nf_k2_selB", fwdSelB2, 0);
        chk("nf_k2_cnt", stallCount2, 1);
      end
      if (k == 3) begin
        chk("nf_k3_stall", stall2, 0);
        chk("nf_k3_cnt", stallCount2, 2);
      end
      if (k == 6) chk("nf_k6_cnt", stallCount2, 4);
      if (k == 67) begin
        chk("sat_stall", stall2, 1);
        chk("sat_cnt", stallCount2, 4'hF);
      end
      if (k == 68) chk("sat_hold_cnt", stallCount2, 4'hF);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/reg_hazard_ctrl.md
# reg_hazard_ctrl

Hazard and forwarding controller for the register file in the 16-bit pipeline (stages ID, EX, MEM, WB). It sits beside the ID stage and tracks every in-flight register write in EX and MEM. From those writes it tells ID whether the current instruction must stall, and where each source operand must be forwarded from once the instruction reaches EX. It also counts stall cycles for performance debug.

## Interface
- FORWARDING, default 1: 1 = EX/MEM forwarding paths exist; 0 = any dependence on EX or MEM stalls, and fwdSelA/fwdSelB stay 2'b00.
- CLK  in  1  pipeline clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- issueValid  in  1  a valid instruction occupies ID.
- srcAUsed  in  1  instruction reads port 1.
- srcASpec  in  2  port-1 register class: 00 general, 01 SP, 10 IH, 11 T.
- srcAIdx  in  3  port-1 general register index; ignored unless srcASpec=00.
- srcBUsed  in  1  instruction reads port 2, which is general only.
- srcBIdx  in  3  port-2 general register index.
- dstWrite  in  1  instruction writes a register.
- dstSpec  in  2  destination class, same encoding as srcASpec.
- dstIdx  in  3  destination general index.
- dstIsLoad  in  1  destination value comes from memory; available only at end of MEM.
- flush  in  1  instruction in ID is squashed this cycle.
- hold  in  1  whole pipeline frozen this cycle (memory wait).
- stall  out  1  ID must not advance this cycle; combinational.
- fwdSelA  out  2  port-1 source for the consumer's EX cycle: 00 regfile, 01 MEM-stage result, 10 WB-stage result; combinational.
- fwdSelB  out  2  same for port 2.
- stallCount  out  16  saturating count of stall cycles.

## Operation
- Register ID (4 bits): general n gives n (0-7); SP gives 8; IH gives 9; T gives 10.
- Two tracking slots, each holding {valid, id[3:0], isLoad}:
  - slotEX: the producer now in EX.
  - slotMEM: the producer now in MEM.
- A producer in WB needs no tracking, because the regfile writes on negedge CLK and ID reads after it.
- Match for a source: the source is used, the slot is valid, and the IDs are equal. EX takes priority over MEM, so the newest producer wins.
- Per source, with FORWARDING=1:
  - EX match with isLoad=1: request stall; fwdSel=00.
  - EX match with isLoad=0: fwdSel=01.
  - MEM match only: fwdSel=10.
  - No match: fwdSel=00.
- With FORWARDING=0: any EX or MEM match requests stall.
- stall = issueValid & !flush & (srcA request | srcB request).
- fwdSel outputs are qualified by nothing else. The ID/EX register captures them only when the instruction advances.
- Slot update at posedge, in priority order:
  - hold=1: both slots keep their values.
  - else flush=1: slotMEM <= slotEX; slotEX <= bubble.
  - else stall=1: slotMEM <= slotEX; slotEX <= bubble.
  - else: slotMEM <= slotEX; slotEX <= {issueValid & dstWrite, dstID, dstIsLoad}.
- When issueValid=0 or dstWrite=0, slotEX becomes a bubble; the stored id and isLoad values are don't-care.
- stallCount increments when stall=1 and hold=0. It saturates at 16'hFFFF and clears only on RST.

## Timing
- RST asserted: slots invalid, stall=0, fwdSelA=fwdSelB=00, stallCount=0, all immediately (asynchronous).
- RST deasserted mid-stream: the first posedge after release starts from empty slots.
- stall and fwdSel are combinational from the slots and ID inputs within the same cycle. They have no registered latency.
- Load-use costs exactly 1 stall cycle:
  - The cycle after the stall, the load sits in MEM.
  - The consumer then sees a MEM match and gets fwdSel=10.
- One ALU producer followed by a dependent instruction costs 0 stall cycles (fwdSel=01).
- A source matching both slots uses the EX slot.
- A general register n never matches SP, IH or T, because their IDs differ.
- flush and stall in the same cycle: flush wins. stall is forced to 0 and stallCount does not increment.
- hold with a stall condition: stall output stays asserted, the slots freeze, and stallCount does not increment.

## Test plan
- Reset: assert RST while slots are valid, with no clock edge -> slots clear, stall=0, fwdSel=00, stallCount=0.
- ALU chain: R1 <- R2+R3, then R4 <- R1+R1 next cycle -> stall=0, fwdSelA=fwdSelB=01. One cycle later, a reader of R1 gets fwdSel=10. Two cycles later it gets 00.
- Load-use: LW R5, then ADD reading R5 on port 2 -> stall=1 for 1 cycle, stallCount=1. The following cycle gives stall=0 and fwdSelB=10.
- Special registers: write SP (01), then the reader uses srcASpec=01 -> fwdSelA=01. A reader of T (11), or of general R0, with SP in flight -> fwdSelA=00.
- Newest wins: write R2 (load), then write R2 (ALU), then read R2 -> fwdSelA=01, stall=0.
- Flush, hold and saturation:
  - flush on a dependent load-use instruction -> stall=0 and slotEX becomes a bubble.
  - hold for 3 cycles during a stall -> slots unchanged and stallCount unchanged.
  - Preload stallCount to 16'hFFFF via sustained stalls -> the counter stays at FFFF.
